// File: rtl/sat_accum_if.sv
// Stream interface for sat_accum: term input stream and group-result output.
// SAT_ACCUM_FLAG_EN adds the out_sat result flag.
interface sat_accum_if #(
   parameter int W     = 16,
   parameter int CNT_W = 6
);
   logic [W-1:0]     in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [W-1:0]     out_data;
   logic [CNT_W-1:0] out_cnt;
   logic             out_valid;
   logic             out_ready;
`ifdef SAT_ACCUM_FLAG_EN
   logic             out_sat;
`endif

   // Accumulator side
   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_cnt, out_valid
`ifdef SAT_ACCUM_FLAG_EN
      , output out_sat
`endif
   );

   // Producer/consumer side
   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_cnt, out_valid
`ifdef SAT_ACCUM_FLAG_EN
      , input out_sat
`endif
   );
endinterface

// File: rtl/sat_accum.sv
// Streaming saturating accumulator for LLR messages (signed INT.FRAC).
// Each accepted beat is added with a per-step clamp; the group total is
// presented on a valid/ready result port.
// Optional feature macro: SAT_ACCUM_FLAG_EN (adds sticky out_sat flag).
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting terms, in_ready=1
// HOLD  | group result valid, waiting for out_ready, in_ready=0
module sat_accum #(
   parameter int INT   = 8,
   parameter int FRAC  = 8,
   parameter int CNT_W = 6
) (
   input logic      clk,
   input logic      rst_n,
   sat_accum_if.slave bus
);
   localparam int W = INT + FRAC;

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     acc;
   logic             first;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     out_data_q;
   logic [CNT_W-1:0] out_cnt_q;
   logic             out_valid_q;

   logic [W-1:0]     raw_sum;
   logic [W-1:0]     sat_sum;
   logic [W-1:0]     nxt;
   logic             clamp;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             in_ready_c;

   // Saturating add of the running sum and the incoming term
   always_comb begin
      raw_sum = acc + bus.in_data;
      clamp   = (acc[W-1] == bus.in_data[W-1]) && (raw_sum[W-1] != acc[W-1]);
      sat_sum = raw_sum;
      if (clamp)
         sat_sum = acc[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      nxt     = first ? bus.in_data : sat_sum;
      cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   end

   // Next-state and handshake decode
   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      accept     = 1'b0;
      case (state)
         ACC: begin
            in_ready_c = 1'b1;
            accept     = bus.in_valid;
            if (bus.in_valid && bus.in_last)
               state_nxt = HOLD;
         end
         HOLD: begin
            if (out_valid_q && bus.out_ready)
               state_nxt = ACC;
         end
         default: state_nxt = ACC;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ACC;
      else        state <= state_nxt;
   end

   // Running sum, term counter and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc         <= '0;
         first       <= 1'b1;
         cnt         <= '0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         acc <= nxt;
         if (bus.in_last) begin
            first       <= 1'b1;
            cnt         <= '0;
            out_data_q  <= nxt;
            out_cnt_q   <= cnt_inc;
            out_valid_q <= 1'b1;
         end else begin
            first <= 1'b0;
            cnt   <= cnt_inc;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef SAT_ACCUM_FLAG_EN
   logic step_clamp;
   logic sticky;
   logic out_sat_q;

   // The first term of a group is loaded, never added, so it cannot clamp
   assign step_clamp = clamp && !first;

   // Sticky clamp flag, captured into out_sat alongside out_data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky    <= 1'b0;
         out_sat_q <= 1'b0;
      end else if (accept) begin
         if (bus.in_last) begin
            sticky    <= 1'b0;
            out_sat_q <= (sticky && !first) || step_clamp;
         end else begin
            sticky    <= (sticky && !first) || step_clamp;
         end
      end
   end

   assign bus.out_sat = out_sat_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.out_data  = out_data_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.out_valid = out_valid_q;
endmodule
